// File: rtl/delay_mem_arbiter_pkg.sv
// Shared constants for the delay-memory arbiter.
//   - requester indices (bit positions in req/wr/gnt/rvalid)
//   - arbiter FSM state encodings
//   - ring_add:   modulo-3 increment used by the round-robin pointer
//   - req_onehot: requester index to one-hot grant/valid vector
package delay_mem_arbiter_pkg;

    localparam int NUM_REQ = 3;

    localparam logic [1:0] PIPELINE_A = 2'd0;
    localparam logic [1:0] PIPELINE_B = 2'd1;
    localparam logic [1:0] CTRL       = 2'd2;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_DRAIN   = 2'd1;
    localparam logic [1:0] ST_HALTED  = 2'd2;

    // (base + off) mod 3, both operands expected in 0..2.
    function automatic logic [1:0] ring_add(input logic [1:0] base, input logic [1:0] off);
        logic [2:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    endfunction

    function automatic logic [2:0] req_onehot(input logic [1:0] idx);
        logic [2:0] vec;
        case (idx)
            PIPELINE_A: vec = 3'b001;
            PIPELINE_B: vec = 3'b010;
            CTRL:       vec = 3'b100;
            default:    vec = 3'b000;
        endcase
        return vec;
    endfunction

endpackage

// File: rtl/fifo_buffer.sv
// Synchronous show-ahead FIFO: dout always presents the oldest entry, so a
// pop and its data are used in the same cycle.
// Ports: clk, reset (sync, active-low), wr_en/din push, rd_en pop,
//        dout head entry, full/empty flags, count occupancy (0..n).
// n must be a power of two (>= 2) so the pointers wrap naturally.
module fifo_buffer #(
    parameter int data_width = 8,
    parameter int n          = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [data_width-1:0] din,
    output logic [data_width-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic [$clog2(n):0]    count
);

    localparam int PW = $clog2(n);
    localparam int CW = PW + 1;

    logic [data_width-1:0] mem_r [n];
    logic [PW-1:0]         wr_ptr_r;
    logic [PW-1:0]         rd_ptr_r;
    logic [CW-1:0]         count_r;
    logic                  do_wr_s;
    logic                  do_rd_s;

    assign do_wr_s = wr_en & ~full;
    assign do_rd_s = rd_en & ~empty;

    // Storage array; contents need no reset because count gates validity.
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            wr_ptr_r <= do_wr_s ? wr_ptr_r + PW'(1) : wr_ptr_r;
            rd_ptr_r <= do_rd_s ? rd_ptr_r + PW'(1) : rd_ptr_r;
            case ({do_wr_s, do_rd_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign full  = (count_r == CW'(n));
    assign empty = (count_r == {CW{1'b0}});
    assign count = count_r;

endmodule

// File: rtl/delay_mem_arbiter.sv
// Round-robin arbiter sharing one delay memory between pipeline_a,
// pipeline_b and the control unit, with in-order read-return routing and a
// flush/drain handshake used before delay reallocation.
// Ports:
//   req/wr/addr/wdata   per-requester access (requester i at slice i)
//   gnt                 one-hot: access accepted this cycle
//   rvalid/rdata        one-hot owner of the returning read data
//   mem_*               memory command / ready / in-order read return
//   flush/flushed       quiescence request / halted with no reads in flight
//   error               sticky: read data returned with nothing outstanding
// Command and return paths are combinational; all of them are forced to zero
// while reset is low.
module delay_mem_arbiter
    import delay_mem_arbiter_pkg::*;
#(
    parameter int data_width      = 16,
    parameter int addr_width      = 18,
    parameter int max_outstanding = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2:0]              req,
    input  logic [2:0]              wr,
    input  logic [3*addr_width-1:0] addr,
    input  logic [3*data_width-1:0] wdata,
    output logic [2:0]              gnt,
    output logic [2:0]              rvalid,
    output logic [data_width-1:0]   rdata,
    output logic                    mem_req,
    output logic                    mem_wr,
    output logic [addr_width-1:0]   mem_addr,
    output logic [data_width-1:0]   mem_wdata,
    input  logic                    mem_ready,
    input  logic                    mem_rvalid,
    input  logic [data_width-1:0]   mem_rdata,
    input  logic                    flush,
    output logic                    flushed,
    output logic                    error
);

    localparam int CW = $clog2(max_outstanding) + 1;

    logic [1:0]            state_r;
    logic [1:0]            state_nxt_s;
    logic [1:0]            rr_ptr_r;
    logic                  error_r;
    logic [2:0]            elig_s;
    logic                  win_valid_s;
    logic                  win_hit_s;
    logic [1:0]            win_idx_s;
    logic [1:0]            cand_s;
    logic                  mem_req_s;
    logic                  mem_wr_s;
    logic [addr_width-1:0] mem_addr_s;
    logic [data_width-1:0] mem_wdata_s;
    logic [2:0]            gnt_s;
    logic [2:0]            rvalid_s;
    logic [data_width-1:0] rdata_s;
    logic                  tag_push_s;
    logic                  tag_pop_s;
    logic                  tag_full_s;
    logic                  tag_empty_s;
    logic [1:0]            tag_dout_s;
    logic [CW-1:0]         tag_count_s;
    logic                  drain_done_s;

    // Round-robin search: first eligible requester at or after rr_ptr.
    // Reads are held back while every tag slot is in use; writes never are.
    always_comb begin
        elig_s      = req & (wr | {3{~tag_full_s}});
        win_valid_s = 1'b0;
        win_idx_s   = rr_ptr_r;
        cand_s      = rr_ptr_r;
        win_hit_s   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s      = ring_add(rr_ptr_r, 2'(k));
            win_hit_s   = ~win_valid_s & elig_s[cand_s];
            win_idx_s   = win_hit_s ? cand_s : win_idx_s;
            win_valid_s = win_valid_s | win_hit_s;
        end
    end

    // Memory command from the winner; nothing is offered outside RUN.
    always_comb begin
        mem_req_s = reset & (state_r == ST_RUN) & win_valid_s;
        if (mem_req_s) begin
            mem_wr_s    = wr[win_idx_s];
            mem_addr_s  = addr[win_idx_s*addr_width +: addr_width];
            mem_wdata_s = wdata[win_idx_s*data_width +: data_width];
        end else begin
            mem_wr_s    = 1'b0;
            mem_addr_s  = {addr_width{1'b0}};
            mem_wdata_s = {data_width{1'b0}};
        end
        gnt_s      = (mem_req_s & mem_ready) ? req_onehot(win_idx_s) : 3'b000;
        tag_push_s = mem_req_s & mem_ready & ~mem_wr_s;
    end

    // Read return: the oldest tag names the owner of this beat.
    always_comb begin
        tag_pop_s = reset & mem_rvalid & ~tag_empty_s;
        if (tag_pop_s) begin
            rvalid_s = req_onehot(tag_dout_s);
            rdata_s  = mem_rdata;
        end else begin
            rvalid_s = 3'b000;
            rdata_s  = {data_width{1'b0}};
        end
    end

    // Drain completes in the cycle the last outstanding read returns, so
    // flushed rises on the following cycle.
    always_comb begin
        drain_done_s = (tag_count_s == {CW{1'b0}}) |
                       ((tag_count_s == CW'(1)) & tag_pop_s);
        case (state_r)
            ST_RUN:    state_nxt_s = flush ? ST_DRAIN : ST_RUN;
            ST_DRAIN:  state_nxt_s = drain_done_s ? ST_HALTED : ST_DRAIN;
            ST_HALTED: state_nxt_s = flush ? ST_HALTED : ST_RUN;
            default:   state_nxt_s = ST_RUN;
        endcase
    end

    // FSM state, round-robin pointer and sticky error flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= ST_RUN;
            rr_ptr_r <= PIPELINE_A;
            error_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (gnt_s != 3'b000) begin
                rr_ptr_r <= ring_add(win_idx_s, 2'd1);
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
            error_r <= error_r | (mem_rvalid & tag_empty_s);
        end
    end

    fifo_buffer #(
        .data_width(2),
        .n         (max_outstanding)
    ) u_tag_fifo (
        .clk  (clk),
        .reset(reset),
        .wr_en(tag_push_s),
        .rd_en(tag_pop_s),
        .din  (win_idx_s),
        .dout (tag_dout_s),
        .full (tag_full_s),
        .empty(tag_empty_s),
        .count(tag_count_s)
    );

    assign gnt       = gnt_s;
    assign rvalid    = rvalid_s;
    assign rdata     = rdata_s;
    assign mem_req   = mem_req_s;
    assign mem_wr    = mem_wr_s;
    assign mem_addr  = mem_addr_s;
    assign mem_wdata = mem_wdata_s;
    assign flushed   = reset & (state_r == ST_HALTED);
    assign error     = error_r;

endmodule

// File: tb/tb_delay_mem_arbiter.sv
// Self-checking bench for delay_mem_arbiter: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_delay_mem_arbiter;

    localparam int DW   = 16;
    localparam int AW   = 18;
    localparam int MAXO = 4;
    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_HALT  = 2;

    logic            clk;
    logic            reset;
    logic [2:0]      req;
    logic [2:0]      wr;
    logic [3*AW-1:0] addr;
    logic [3*DW-1:0] wdata;
    logic [2:0]      gnt;
    logic [2:0]      rvalid;
    logic [DW-1:0]   rdata;
    logic            mem_req;
    logic            mem_wr;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_ready;
    logic            mem_rvalid;
    logic [DW-1:0]   mem_rdata;
    logic            flush;
    logic            flushed;
    logic            error;

    delay_mem_arbiter #(
        .data_width     (DW),
        .addr_width     (AW),
        .max_outstanding(MAXO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .wr        (wr),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_req   (mem_req),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata),
        .flush     (flush),
        .flushed   (flushed),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model: outstanding read owners in issue order, rotation
    // pointer, operating mode and sticky error.
    int         m_q[$];
    int         m_rr   = 0;
    int         m_mode = M_RUN;
    logic       m_err  = 1'b0;
    logic [2:0] m_last_gnt = 3'b000;

    logic [2:0]    obs_gnt;
    logic [2:0]    obs_rvalid;
    logic          obs_mem_req;
    logic          obs_mem_wr;
    logic [AW-1:0] obs_mem_addr;
    logic [DW-1:0] obs_mem_wdata;
    logic          obs_flushed;
    logic          obs_error;
    logic [DW-1:0] obs_rdata;
    int            pulses;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: sample outputs before the edge, compare with the
    // model, advance the model, then move to just after the edge.
    task automatic step();
        int         w;
        bit         found;
        bit         full_q;
        bit         e_mreq;
        bit         pop;
        logic [2:0] e_gnt;
        logic [2:0] e_rv;
        #3;
        obs_gnt       = gnt;
        obs_rvalid    = rvalid;
        obs_mem_req   = mem_req;
        obs_mem_wr    = mem_wr;
        obs_mem_addr  = mem_addr;
        obs_mem_wdata = mem_wdata;
        obs_flushed   = flushed;
        obs_error     = error;
        obs_rdata     = rdata;
        if (!reset) begin
            check("rst_gnt",     32'(gnt),     32'd0);
            check("rst_rvalid",  32'(rvalid),  32'd0);
            check("rst_rdata",   32'(rdata),   32'd0);
            check("rst_mem_req", 32'(mem_req), 32'd0);
            check("rst_flushed", 32'(flushed), 32'd0);
            m_q.delete();
            m_rr       = 0;
            m_mode     = M_RUN;
            m_err      = 1'b0;
            m_last_gnt = 3'b000;
        end else begin
            full_q = (m_q.size() >= MAXO);
            found  = 1'b0;
            w      = 0;
            for (int k = 0; k < 3; k++) begin
                int i;
                i = (m_rr + k) % 3;
                if (!found && req[i] && (wr[i] || !full_q)) begin
                    found = 1'b1;
                    w     = i;
                end
            end
            e_mreq = (m_mode == M_RUN) && found;
            e_gnt  = (e_mreq && mem_ready) ? 3'(1 << w) : 3'b000;
            pop    = mem_rvalid && (m_q.size() > 0);
            e_rv   = pop ? 3'(1 << m_q[0]) : 3'b000;
            check("mem_req", 32'(mem_req), 32'(e_mreq));
            check("gnt",     32'(gnt),     32'(e_gnt));
            check("rvalid",  32'(rvalid),  32'(e_rv));
            check("flushed", 32'(flushed), 32'(m_mode == M_HALT));
            check("error",   32'(error),   32'(m_err));
            if (e_mreq) begin
                check("mem_wr",   32'(mem_wr),   32'(wr[w]));
                check("mem_addr", 32'(mem_addr), 32'(addr[w*AW +: AW]));
                if (wr[w]) check("mem_wdata", 32'(mem_wdata), 32'(wdata[w*DW +: DW]));
            end
            if (pop) check("rdata", 32'(rdata), 32'(mem_rdata));
            if (mem_rvalid && !pop) m_err = 1'b1;
            if (pop) void'(m_q.pop_front());
            if (e_gnt != 3'b000) begin
                if (!wr[w]) m_q.push_back(w);
                m_rr = (w + 1) % 3;
            end
            case (m_mode)
                M_RUN:   if (flush) m_mode = M_DRAIN;
                M_DRAIN: if (m_q.size() == 0) m_mode = M_HALT;
                default: if (!flush) m_mode = M_RUN;
            endcase
            m_last_gnt = e_gnt;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] r, input logic [2:0] w, input logic rdy, input logic rv);
        req        = r;
        wr         = w;
        mem_ready  = rdy;
        mem_rvalid = rv;
        mem_rdata  = DW'($urandom);
    endtask

    task automatic drain_all();
        flush = 1'b0;
        for (int k = 0; k < 8 && m_q.size() > 0; k++) begin
            drive(3'b000, 3'b000, 1'b1, 1'b1);
            step();
        end
        drive(3'b000, 3'b000, 1'b1, 1'b0);
        step();
    endtask

    task automatic new_access(input int i);
        req[i] = 1'b1;
        wr[i]  = ($urandom_range(0, 2) == 0);
        addr[i*AW +: AW]  = AW'($urandom);
        wdata[i*DW +: DW] = DW'($urandom);
    endtask

    initial begin
        reset = 1'b0; req = 3'b000; wr = 3'b000; addr = '0; wdata = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; flush = 1'b0;
        step();
        step();
        reset = 1'b1;
        drive(3'b000, 3'b000, 1'b1, 1'b0);
        step();
        check("post_rst_error",   32'(obs_error),   32'd0);
        check("post_rst_flushed", 32'(obs_flushed), 32'd0);

        // Two pipelines reading back-to-back with immediate returns.
        for (int k = 0; k < 6; k++) begin
            addr[0 +: AW]  = AW'(k);
            addr[AW +: AW] = AW'(18'h00100 + k);
            drive(3'b011, 3'b000, 1'b1, m_q.size() > 0);
            step();
            check("alt_gnt", 32'(obs_gnt), (k % 2 == 0) ? 32'd1 : 32'd2);
            if (k > 0) check("alt_rvalid", 32'(obs_rvalid), (k % 2 == 1) ? 32'd1 : 32'd2);
        end
        drain_all();

        // Fill all tag slots from pipeline_a, then block pipeline_b's read.
        for (int k = 0; k < 4; k++) begin
            drive(3'b001, 3'b000, 1'b1, 1'b0);
            step();
            check("fill_gnt", 32'(obs_gnt), 32'd1);
        end
        drive(3'b110, 3'b100, 1'b1, 1'b0);
        step();
        check("full_ctrl_write", 32'(obs_gnt), 32'd4);
        for (int k = 0; k < 2; k++) begin
            drive(3'b010, 3'b000, 1'b1, 1'b0);
            step();
            check("full_b_blocked", 32'(obs_gnt), 32'd0);
            check("full_no_mem_req", 32'(obs_mem_req), 32'd0);
        end
        drive(3'b010, 3'b000, 1'b1, 1'b1);
        step();
        check("full_return", 32'(obs_rvalid), 32'd1);
        check("full_still_blocked", 32'(obs_gnt), 32'd0);
        drive(3'b010, 3'b000, 1'b1, 1'b0);
        step();
        check("full_b_granted", 32'(obs_gnt), 32'd2);
        drain_all();

        // pipeline_b write held against a stalled memory.
        addr[AW +: AW]  = 18'h00010;
        wdata[DW +: DW] = 16'h7FFF;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            drive(3'b010, 3'b010, (k == 3), 1'b0);
            step();
            pulses += int'(obs_gnt[1]);
            check("stall_mem_req",   32'(obs_mem_req),   32'd1);
            check("stall_mem_wr",    32'(obs_mem_wr),    32'd1);
            check("stall_mem_addr",  32'(obs_mem_addr),  32'h10);
            check("stall_mem_wdata", 32'(obs_mem_wdata), 32'h7FFF);
        end
        drive(3'b000, 3'b000, 1'b1, 1'b0);
        step();
        pulses += int'(obs_gnt[1]);
        check("stall_gnt_pulses", 32'(pulses), 32'd1);
        drain_all();

        // Flush with two reads in flight.
        for (int k = 0; k < 2; k++) begin
            drive(3'b001, 3'b000, 1'b1, 1'b0);
            step();
            check("flush_setup_gnt", 32'(obs_gnt), 32'd1);
        end
        flush = 1'b1;
        drive(3'b000, 3'b000, 1'b1, 1'b0);
        step();
        drive(3'b001, 3'b000, 1'b1, 1'b0);
        step();
        check("drain_no_mem_req", 32'(obs_mem_req), 32'd0);
        drive(3'b001, 3'b000, 1'b1, 1'b1);
        step();
        check("drain_ret1_no_mem_req", 32'(obs_mem_req), 32'd0);
        check("drain_ret1_flushed", 32'(obs_flushed), 32'd0);
        drive(3'b001, 3'b000, 1'b1, 1'b1);
        step();
        check("drain_ret2_flushed", 32'(obs_flushed), 32'd0);
        flush = 1'b0;
        drive(3'b001, 3'b000, 1'b1, 1'b0);
        step();
        check("halted_flushed", 32'(obs_flushed), 32'd1);
        check("halted_no_mem_req", 32'(obs_mem_req), 32'd0);
        drive(3'b001, 3'b000, 1'b1, 1'b0);
        step();
        check("resume_gnt", 32'(obs_gnt), 32'd1);
        drain_all();

        // Stray read return sets a sticky error cleared only by reset.
        drive(3'b000, 3'b000, 1'b1, 1'b1);
        step();
        check("stray_rvalid", 32'(obs_rvalid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            drive(3'b000, 3'b000, 1'b1, 1'b0);
            step();
            check("stray_error_sticky", 32'(obs_error), 32'd1);
        end
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        check("error_cleared", 32'(obs_error), 32'd0);

        // Reset with three reads in flight.
        for (int k = 0; k < 3; k++) begin
            drive(3'b011, 3'b000, 1'b1, 1'b0);
            step();
            check("pre_rst_gnt", 32'(obs_gnt), (k % 2 == 0) ? 32'd1 : 32'd2);
        end
        reset = 1'b0;
        drive(3'b011, 3'b000, 1'b1, 1'b1);
        step();
        check("midrst_gnt", 32'(obs_gnt), 32'd0);
        check("midrst_rvalid", 32'(obs_rvalid), 32'd0);
        check("midrst_rdata", 32'(obs_rdata), 32'd0);
        reset = 1'b1;
        drive(3'b000, 3'b000, 1'b1, 1'b1);
        step();
        check("post_rst_stray_rvalid", 32'(obs_rvalid), 32'd0);
        drive(3'b011, 3'b000, 1'b1, 1'b0);
        step();
        check("post_rst_first_gnt", 32'(obs_gnt), 32'd1);
        check("post_rst_stray_error", 32'(obs_error), 32'd1);
        reset = 1'b0;
        drive(3'b000, 3'b000, 1'b0, 1'b0);
        step();
        reset = 1'b1;

        // Randomized traffic; requesters hold each access until granted.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (m_last_gnt[i]) begin
                    if ($urandom_range(0, 99) < 60) new_access(i);
                    else req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 99) < 30) begin
                    new_access(i);
                end
            end
            mem_ready  = ($urandom_range(0, 3) != 0);
            mem_rvalid = (m_q.size() > 0) && ($urandom_range(0, 99) < 45);
            mem_rdata  = DW'($urandom);
            if ($urandom_range(0, 99) < 4) flush = ~flush;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
